cryptoprocessor_host_bridge_1506: RTL

//  Upstream host bridge for cryptoprocessor_wrapper_1506. Converts a 32-bit valid/ready word stream into the

---
 rtl/cp_host_pkg.sv | 41 ++++
 rtl/cryptoprocessor_host_bridge_1506_if.sv | 26 ++
 rtl/cp_word_serializer.sv | 47 ++++
 rtl/cryptoprocessor_host_bridge_1506.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cp_host_pkg.sv
// rtl/cp_host_pkg.sv - shared sizes, opcodes, field positions and state codes for the host bridge
// Purpose : constants shared by the bridge, its interface and the readback serializer.
// Ports   : none (package).
package cp_host_pkg;

  localparam int DW       = 1506;                  // operand share width
  localparam int WW       = 32;                    // host word width
  localparam int NW       = (DW + WW - 1) / WW;    // words per share (48)
  localparam int WORDS    = 2 * NW;                // words per load / readback (96)
  localparam int SHARE_W  = NW * WW;               // share width padded to whole words
  localparam int BUF_W    = 2 * SHARE_W;           // both padded shares
  localparam int CNT_W    = $clog2(WORDS);
  localparam int READ_LAT = 1;                     // get_output -> valid dout
  localparam int RL_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  // Command layout {op[23:21], src1[20:14], src2[13:7], dst[6:0]}; header bit 31 = RD.
  localparam int CMD_W  = 24;
  localparam int OP_HI  = 23;
  localparam int OP_LO  = 21;
  localparam int HDR_RD = 31;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_RD_REQ = 3'd3;
  localparam logic [2:0] ST_SEND   = 3'd4;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_COPY = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_MUL  = 3'd5
  } cp_op_e;

  function automatic logic [2:0] cmd_op(input logic [CMD_W-1:0] cmd);
    return cmd[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/cryptoprocessor_host_bridge_1506_if.sv
// rtl/cryptoprocessor_host_bridge_1506_if.sv - host word streams of the bridge
// Purpose : bundles the inbound header/operand stream and the outbound readback stream.
// Signals : s_valid/s_ready/s_data (host -> bridge), m_valid/m_ready/m_data/m_last (bridge -> host).
// Modports: slave = bridge side, master = host side.
interface cryptoprocessor_host_bridge_1506_if;
  import cp_host_pkg::*;

  logic          s_valid;
  logic          s_ready;
  logic [WW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [WW-1:0] m_data;
  logic          m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/cp_word_serializer.sv
// rtl/cp_word_serializer.sv - parallel-in serial-out of both result shares as host words
// Purpose : captures {pad(dout_2), pad(dout_1)} on load and streams WORDS words, LSW first.
// Ports   : clk, rst_n      clock, async active-low reset
//           load, load_data capture request and padded readback image
//           m_valid/m_ready/m_data/m_last  outbound word stream
module cp_word_serializer
  import cp_host_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BUF_W-1:0] load_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WW-1:0]    m_data,
  output logic             m_last
);

  logic [BUF_W-1:0] sreg;
  logic [CNT_W-1:0] cnt;

  // Current word is always the bottom of the shift register, so it stays put while stalled.
  assign m_data = sreg[WW-1:0];
  assign m_last = m_valid && (cnt == CNT_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
    end else if (load) begin
      sreg    <= load_data;
      cnt     <= '0;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      if (m_last) begin
        sreg    <= '0;
        cnt     <= '0;
        m_valid <= 1'b0;
      end else begin
        sreg <= sreg >> WW;
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cryptoprocessor_host_bridge_1506.sv
// rtl/cryptoprocessor_host_bridge_1506.sv - host word stream to cryptoprocessor wrapper bridge
// Purpose : decodes header words, assembles operand shares, issues one instruction per header
//           and streams result shares back on a read header.
// Ports   : clk, rst_n                     clock, async active-low reset
//           bus (slave)                    inbound s_* and outbound m_* word streams
//           busy                           bridge not idle
//           cp_ins_in/cp_data_en/cp_get_output, cp_command, cp_din_1/2   wrapper request side
//           cp_dout_1/2                    wrapper result shares
module cryptoprocessor_host_bridge_1506
  import cp_host_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  cryptoprocessor_host_bridge_1506_if.slave bus,
  output logic                 busy,
  output logic                 cp_ins_in,
  output logic                 cp_data_en,
  output logic                 cp_get_output,
  output logic [CMD_W-1:0]     cp_command,
  output logic [DW-1:0]        cp_din_1,
  output logic [DW-1:0]        cp_din_2,
  input  logic [DW-1:0]        cp_dout_1,
  input  logic [DW-1:0]        cp_dout_2
);

  logic [2:0]          state;
  logic [2:0]          nxt;
  logic [CNT_W-1:0]    wcnt;
  logic [RL_W-1:0]     rd_cnt;
  logic [CMD_W-1:0]    hdr_q;
  logic [BUF_W-WW-1:0] sipo;       // first WORDS-1 operand words; the last one arrives on s_data
  logic [BUF_W-1:0]    sipo_next;
  logic [BUF_W-1:0]    rb_data;
  logic                s_fire;
  logic                hdr_fire;
  logic                load_last;
  logic                rd_last;
  logic                m_done;
  logic                unused_pad;

  assign s_fire    = bus.s_valid && bus.s_ready;
  assign hdr_fire  = (state == ST_IDLE) && s_fire;
  assign load_last = (state == ST_LOAD) && s_fire && (wcnt == CNT_W'(WORDS - 1));
  assign rd_last   = (state == ST_RD_REQ) && (rd_cnt == RL_W'(READ_LAT - 1));
  assign m_done    = bus.m_valid && bus.m_ready && bus.m_last;
  assign busy      = (state != ST_IDLE);

  // Words enter at the top, so after the final word word 0 sits at bit 0.
  assign sipo_next = {bus.s_data, sipo};
  // Bits above DW in each share's top word are dropped.
  assign unused_pad = ^{sipo_next[SHARE_W-1:DW], sipo_next[BUF_W-1:SHARE_W+DW]};

  assign rb_data = {{(SHARE_W-DW){1'b0}}, cp_dout_2, {(SHARE_W-DW){1'b0}}, cp_dout_1};

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (s_fire) begin
          if (bus.s_data[HDR_RD])                            nxt = ST_RD_REQ;
          else if (cmd_op(bus.s_data[CMD_W-1:0]) == OP_LOAD) nxt = ST_LOAD;
          else if (cmd_op(bus.s_data[CMD_W-1:0]) != OP_NOP)  nxt = ST_ISSUE;
        end
      end
      ST_LOAD:   if (load_last) nxt = ST_ISSUE;
      ST_ISSUE:  nxt = ST_IDLE;
      ST_RD_REQ: if (rd_last) nxt = ST_SEND;
      ST_SEND:   if (m_done) nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bus.s_ready   <= 1'b0;
      wcnt          <= '0;
      rd_cnt        <= '0;
      hdr_q         <= '0;
      sipo          <= '0;
      cp_ins_in     <= 1'b0;
      cp_data_en    <= 1'b0;
      cp_get_output <= 1'b0;
      cp_command    <= '0;
      cp_din_1      <= '0;
      cp_din_2      <= '0;
    end else begin
      state         <= nxt;
      // Registered from the next state so it stays low through reset and rises one edge later.
      bus.s_ready   <= (nxt == ST_IDLE) || (nxt == ST_LOAD);
      cp_ins_in     <= (nxt == ST_ISSUE);
      // Only a completed load reaches ISSUE with opcode 1.
      cp_data_en    <= load_last;
      cp_get_output <= (nxt == ST_RD_REQ);

      if (hdr_fire) hdr_q <= bus.s_data[CMD_W-1:0];

      // Command and operands change only on entry to a strobe state.
      if (hdr_fire && ((nxt == ST_ISSUE) || (nxt == ST_RD_REQ)))
        cp_command <= bus.s_data[CMD_W-1:0];
      else if (load_last)
        cp_command <= hdr_q;

      if ((state == ST_LOAD) && s_fire) begin
        sipo <= sipo_next[BUF_W-1:WW];
        wcnt <= load_last ? '0 : wcnt + 1'b1;
      end

      if (load_last) begin
        cp_din_1 <= sipo_next[DW-1:0];
        cp_din_2 <= sipo_next[SHARE_W+DW-1:SHARE_W];
      end

      if (state == ST_RD_REQ) rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
    end
  end

  cp_word_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rd_last),
    .load_data (rb_data),
    .m_valid   (bus.m_valid),
    .m_ready   (bus.m_ready),
    .m_data    (bus.m_data),
    .m_last    (bus.m_last)
  );

endmodule
